md_execute_unit: RTL
====================

MD_EXECUTE_UNIT -- requirements
Module: md_execute_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (rst==0 resets).
REQ-003 SHALL have port Start_E, input, 1, RV32M instruction valid in EX.
REQ-004 SHALL have port MDOp_E, input, 3, funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have ports RD1_E and RD2_E, input, 32 each, ID/EX register-file operands.
REQ-006 SHALL have port ALUResult_M, input, 32, EX/MEM forwarded value.
REQ-007 SHALL have port Result_W, input, 32, MEM/WB forwarded value.
REQ-008 SHALL have ports ForwardAE and ForwardBE, input, 2 each, forwarding selects: 00 ID/EX, 10 EX/MEM, 01 MEM/WB.
REQ-009 SHALL have port Flush_E, input, 1, aborts the in-flight operation.
REQ-010 SHALL have port Stall_MD, output, 1, holds IF/ID/EX while high.
REQ-011 SHALL have port MDDone, output, 1, one-cycle result-valid strobe.
REQ-012 SHALL have port MDResult, output, 32, result of the last completed operation.

Function
REQ-013 SHALL select operand A from RD1_E, ALUResult_M or Result_W per ForwardAE; code 11 SHALL select RD1_E. Operand B SHALL follow the same rule with ForwardBE and RD2_E.
REQ-014 SHALL capture both selected operands and MDOp_E only in the IDLE cycle in which Start_E==1; later changes on the forwarding inputs SHALL have no effect on that operation.
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-016 IDLE with Start_E==1 and MDOp_E[2]==0 SHALL go to MUL; with MDOp_E[2]==1 it SHALL go to DIV, except for the special cases of REQ-022/023, which SHALL go directly to DONE.
REQ-017 MUL SHALL form the registered 64-bit product in one cycle and SHALL then go to DONE. MUL SHALL return bits [31:0]; MULH, MULHSU and MULHU SHALL return bits [63:32] (signed×signed, signed×unsigned and unsigned×unsigned respectively).
REQ-018 DIV SHALL run a restoring radix-2 divide on the operand magnitudes, 32 iterations (one per cycle, with a 6-bit counter), and SHALL then go to DONE.
REQ-019 For signed ops, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-020 DONE SHALL assert MDDone for exactly one cycle, SHALL load MDResult, and SHALL return to IDLE.
REQ-021 Stall_MD SHALL be 1 combinationally in IDLE while Start_E==1, and 1 in MUL and DIV; it SHALL be 0 in DONE, so the instruction leaves EX at the end of DONE.
REQ-022 A divisor of 0 SHALL give DIV/DIVU quotient 0xFFFFFFFF and REM/REMU result equal to the dividend.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV result 0x80000000 and REM result 0.
REQ-024 Latency from the start cycle to MDDone SHALL be 2 cycles for multiply, 33 cycles for divide and 1 cycle for the special cases.
REQ-025 Start_E SHALL be ignored in the MUL, DIV and DONE states; no operation SHALL restart from DONE.
REQ-026 Flush_E==1 in any state SHALL force IDLE on the next edge with no MDDone strobe and MDResult unchanged; Flush_E SHALL take priority over Start_E.
REQ-027 MDResult SHALL hold its value between completions.

Reset
REQ-028 rst==0 SHALL immediately force state IDLE, counter 0, MDResult 0x00000000, MDDone 0 and Stall_MD 0, including during a MUL or DIV operation.
REQ-029 After rst deasserts, the first Start_E SHALL be accepted on the next rising edge.

Verification
REQ-030 MUL test: A=7, B=-3 (0xFFFFFFFD), ForwardAE/BE=00 -> Stall_MD high 2 cycles, then MDDone with MDResult=0xFFFFFFEB; MULHU with the same operands -> 0x00000006.
REQ-031 DIV test: DIV -20/3 -> MDDone 33 cycles after start with 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 0x0000000E.
REQ-032 Special-case test: DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; REM 0x80000000/0xFFFFFFFF -> 0x00000000 after 1 cycle.
REQ-033 Forwarding test: ForwardAE=10 with ALUResult_M=12, ForwardBE=01 with Result_W=4, MUL -> 48; changing ALUResult_M and Result_W after the start cycle leaves the result at 48.
REQ-034 Abort test: Flush_E pulsed at DIV cycle 10 -> IDLE, no MDDone, prior MDResult kept; rst pulled low at DIV cycle 5 -> Stall_MD=0 and MDResult=0 immediately.

Source files
------------

// File: rtl/md_execute_unit.sv
// RV32M multiply/divide unit for the EX stage: 2-cycle multiply, 33-cycle restoring divide, 1-cycle divide special cases.
// Holds the pipeline through Stall_MD while busy and pulses MDDone with the registered result.
module md_execute_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start_E,
  input  logic [2:0]  MDOp_E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] Result_W,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic        Flush_E,
  output logic        Stall_MD,
  output logic        MDDone,
  output logic [31:0] MDResult
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, rem_q, quo_q, result_q;
  logic [5:0]  cnt_q;
  logic        done_q;

  logic [31:0] src_a, src_b;
  always_comb begin
    case (ForwardAE)
      2'b10:   src_a = ALUResult_M;
      2'b01:   src_a = Result_W;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b10:   src_b = ALUResult_M;
      2'b01:   src_b = Result_W;
      default: src_b = RD2_E;
    endcase
  end

  // Start-cycle decode of the divide special cases
  logic        start_signed, div_zero, div_ovf;
  logic [31:0] special_res, a_mag;
  assign start_signed = ~MDOp_E[0];
  assign div_zero     = (src_b == 32'd0);
  assign div_ovf      = start_signed && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign special_res  = div_zero ? (MDOp_E[1] ? src_a : 32'hFFFF_FFFF)
                                 : (MDOp_E[1] ? 32'd0 : 32'h8000_0000);
  assign a_mag        = (start_signed && src_a[31]) ? -src_a : src_a;

  logic        a_sx, b_sx;
  logic [63:0] mul_a, mul_b, prod;
  assign a_sx  = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
  assign b_sx  = (op_q[1:0] == 2'b01);
  assign mul_a = {{32{a_sx & a_q[31]}}, a_q};
  assign mul_b = {{32{b_sx & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  logic        div_signed, neg_quo, neg_rem, ge;
  logic [31:0] b_mag, rem_d, quo_d, div_res;
  logic [32:0] rem_sh, sub;
  assign div_signed = ~op_q[0];
  assign b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
  assign rem_sh     = {rem_q, quo_q[31]};
  assign sub        = rem_sh - {1'b0, b_mag};
  // rem_q < divisor always holds, so the subtraction's bit 32 is exactly the borrow
  assign ge         = ~sub[32];
  assign rem_d      = ge ? sub[31:0] : rem_sh[31:0];
  assign quo_d      = {quo_q[30:0], ge};
  assign neg_quo    = div_signed & (a_q[31] ^ b_q[31]);
  assign neg_rem    = div_signed & a_q[31];
  assign div_res    = op_q[1] ? (neg_rem ? -rem_d : rem_d) : (neg_quo ? -quo_d : quo_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Flush_E) begin
        state_q <= S_IDLE;
        cnt_q   <= 6'd0;
      end else begin
        case (state_q)
          S_IDLE: if (Start_E) begin
            op_q  <= MDOp_E;
            a_q   <= src_a;
            b_q   <= src_b;
            rem_q <= 32'd0;
            quo_q <= a_mag;
            cnt_q <= 6'd0;
            if (!MDOp_E[2]) begin
              state_q <= S_MUL;
            end else if (div_zero || div_ovf) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= S_DIV;
            end
          end
          S_MUL: begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
          end
          S_DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= div_res;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Stall_MD = rst & (((state_q == S_IDLE) & Start_E) | (state_q == S_MUL) | (state_q == S_DIV));
  assign MDDone   = done_q;
  assign MDResult = result_q;

endmodule
